mem_arbiter_rr: RTL and testbench

- Parametrised N-port arbiter between per-port cache/memory clients (icache, dcache, later DMA/uncached ports) and the single tagged main-memory interface.
- Successor to the fixed two-port arbiter. Adds:
  - round-robin fairness across N_PORTS;
  - multi-beat write-data locking;
  - per-port outstanding-read credit limits;
  - tag-based response routing with an error flag for unroutable tags.

---
 rtl/mem_arbiter_rr_if.sv | 64 ++++++
 rtl/mem_arbiter_rr.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_rr_if.sv
// Bus bundle between the round-robin arbiter, its client ports and main memory.
// The slave modport is the arbiter's view; the master modport is the
// environment (clients plus memory) that drives the arbiter.
interface mem_arbiter_rr_if #(
  parameter int N_PORTS   = 2,
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int TAG_BITS  = 5
);
  localparam int MASK_BITS = DATA_BITS / 8;

  // client request channel
  logic [N_PORTS-1:0]           port_req_valid;
  logic [N_PORTS-1:0]           port_req_ready;
  logic [N_PORTS-1:0]           port_req_rw;
  logic [N_PORTS*ADDR_BITS-1:0] port_req_addr;
  // client write-data channel
  logic [N_PORTS-1:0]           port_data_valid;
  logic [N_PORTS-1:0]           port_data_ready;
  logic [N_PORTS*DATA_BITS-1:0] port_data_bits;
  logic [N_PORTS*MASK_BITS-1:0] port_data_mask;
  // client read responses
  logic [N_PORTS-1:0]           port_resp_valid;
  logic [DATA_BITS-1:0]         port_resp_data;
  // memory request channel
  logic                         mem_req_valid;
  logic                         mem_req_ready;
  logic                         mem_req_rw;
  logic [ADDR_BITS-1:0]         mem_req_addr;
  logic [TAG_BITS-1:0]          mem_req_tag;
  // memory write-data channel
  logic                         mem_req_data_valid;
  logic                         mem_req_data_ready;
  logic [DATA_BITS-1:0]         mem_req_data_bits;
  logic [MASK_BITS-1:0]         mem_req_data_mask;
  // memory responses
  logic                         mem_resp_valid;
  logic [DATA_BITS-1:0]         mem_resp_data;
  logic [TAG_BITS-1:0]          mem_resp_tag;
  // sticky unroutable-tag flag
  logic                         tag_err;

  modport slave (
    input  port_req_valid, port_req_rw, port_req_addr,
    input  port_data_valid, port_data_bits, port_data_mask,
    input  mem_req_ready, mem_req_data_ready,
    input  mem_resp_valid, mem_resp_data, mem_resp_tag,
    output port_req_ready, port_data_ready, port_resp_valid, port_resp_data,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output tag_err
  );

  modport master (
    output port_req_valid, port_req_rw, port_req_addr,
    output port_data_valid, port_data_bits, port_data_mask,
    output mem_req_ready, mem_req_data_ready,
    output mem_resp_valid, mem_resp_data, mem_resp_tag,
    input  port_req_ready, port_data_ready, port_resp_valid, port_resp_data,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  tag_err
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// N-port round-robin arbiter onto a single tagged main-memory interface.
// Reads are limited per port by an outstanding-read credit counter; a granted
// write locks the data channel to its owner for WRITE_BEATS beats. Responses
// are routed back by tag, and an out-of-range tag raises a sticky error flag.
module mem_arbiter_rr #(
  parameter int N_PORTS         = 2,
  parameter int ADDR_BITS       = 28,
  parameter int DATA_BITS       = 128,
  parameter int TAG_BITS        = 5,
  parameter int WRITE_BEATS     = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            reset,   // asynchronous, active low
  mem_arbiter_rr_if.slave bus
);
  localparam int PTR_BITS  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CRED_BITS = $clog2(MAX_OUTSTANDING + 1);
  localparam int BEAT_BITS = (WRITE_BEATS > 1) ? $clog2(WRITE_BEATS) : 1;
  localparam int MASK_BITS = DATA_BITS / 8;

  localparam logic [CRED_BITS-1:0] CRED_MAX  = CRED_BITS'(MAX_OUTSTANDING);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(WRITE_BEATS - 1);
  localparam logic [PTR_BITS-1:0]  LAST_PORT = PTR_BITS'(N_PORTS - 1);

  typedef enum logic {ST_REQ, ST_WDATA} state_t;

  state_t               state_q;
  logic [PTR_BITS-1:0]  rr_ptr_q;
  logic                 hold_q;
  logic [PTR_BITS-1:0]  hold_port_q;
  logic [PTR_BITS-1:0]  owner_q;
  logic [BEAT_BITS-1:0] beat_q;
  logic                 tag_err_q;

  logic [N_PORTS-1:0]   credit_full;
  logic [N_PORTS-1:0]   elig;
  logic [N_PORTS-1:0]   rsp_hit;
  logic [PTR_BITS-1:0]  search_port;
  logic                 any_elig;
  logic [PTR_BITS-1:0]  grant;
  logic                 grant_rw;
  logic                 fire;
  logic                 in_wdata;
  logic                 beat_fire;
  logic                 tag_ok;

  // Port index base+offs, wrapped modulo N_PORTS.
  function automatic logic [PTR_BITS-1:0] wrap_add(input logic [PTR_BITS-1:0] base,
                                                   input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= N_PORTS) sum = sum - N_PORTS;
    return PTR_BITS'(sum);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_port
      logic [CRED_BITS-1:0] credit_q;
      logic [CRED_BITS-1:0] credit_d;
      logic                 inc;
      logic                 dec;

      // Writes never consume credit; reads stop at the outstanding limit.
      assign credit_full[gi] = (credit_q >= CRED_MAX);
      assign elig[gi]        = bus.port_req_valid[gi] & (bus.port_req_rw[gi] | ~credit_full[gi]);
      assign rsp_hit[gi]     = bus.mem_resp_valid & (bus.mem_resp_tag == TAG_BITS'(gi));

      assign bus.port_req_ready[gi]  = fire & (grant == PTR_BITS'(gi));
      assign bus.port_data_ready[gi] = in_wdata & bus.mem_req_data_ready & (owner_q == PTR_BITS'(gi));
      assign bus.port_resp_valid[gi] = reset & rsp_hit[gi];

      assign inc = fire & ~grant_rw & (grant == PTR_BITS'(gi));
      assign dec = rsp_hit[gi];

      // Saturating credit update; a simultaneous issue and response cancel out.
      always_comb begin
        credit_d = credit_q;
        if (inc && !dec && credit_q != CRED_MAX)
          credit_d = credit_q + CRED_BITS'(1);
        else if (dec && !inc && credit_q != '0)
          credit_d = credit_q - CRED_BITS'(1);
      end

      // Per-port outstanding-read counter.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) credit_q <= '0;
        else        credit_q <= credit_d;
      end
    end
  endgenerate

  // First eligible port at or after rr_ptr, wrapping; lowest offset wins.
  always_comb begin
    search_port = rr_ptr_q;
    any_elig    = 1'b0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (elig[wrap_add(rr_ptr_q, k)]) begin
        search_port = wrap_add(rr_ptr_q, k);
        any_elig    = 1'b1;
      end
    end
  end

  // A stalled grant is frozen so addr/rw/tag stay stable until accepted.
  assign grant    = hold_q ? hold_port_q : search_port;
  assign grant_rw = bus.port_req_rw[grant];

  assign bus.mem_req_valid = reset & (state_q == ST_REQ) & (hold_q | any_elig);
  assign bus.mem_req_rw    = grant_rw;
  assign bus.mem_req_addr  = bus.port_req_addr[grant*ADDR_BITS +: ADDR_BITS];
  assign bus.mem_req_tag   = TAG_BITS'(grant);
  assign fire              = bus.mem_req_valid & bus.mem_req_ready;

  assign in_wdata               = reset & (state_q == ST_WDATA);
  assign bus.mem_req_data_valid = in_wdata & bus.port_data_valid[owner_q];
  assign bus.mem_req_data_bits  = bus.port_data_bits[owner_q*DATA_BITS +: DATA_BITS];
  assign bus.mem_req_data_mask  = bus.port_data_mask[owner_q*MASK_BITS +: MASK_BITS];
  assign beat_fire              = bus.mem_req_data_valid & bus.mem_req_data_ready;

  assign tag_ok             = ({1'b0, bus.mem_resp_tag} < (TAG_BITS + 1)'(N_PORTS));
  assign bus.port_resp_data = bus.mem_resp_data;
  assign bus.tag_err        = tag_err_q;

  // Request/write-data phase control, round-robin pointer and error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_REQ;
      rr_ptr_q    <= '0;
      hold_q      <= 1'b0;
      hold_port_q <= '0;
      owner_q     <= '0;
      beat_q      <= '0;
      tag_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (fire) begin
            hold_q   <= 1'b0;
            rr_ptr_q <= (grant == LAST_PORT) ? '0 : grant + PTR_BITS'(1);
            if (grant_rw) begin
              owner_q <= grant;
              beat_q  <= '0;
              state_q <= ST_WDATA;
            end
          end else if (bus.mem_req_valid) begin
            hold_q      <= 1'b1;
            hold_port_q <= grant;
          end
        end
        ST_WDATA: begin
          if (beat_fire) begin
            beat_q <= beat_q + BEAT_BITS'(1);
            if (beat_q == LAST_BEAT) state_q <= ST_REQ;
          end
        end
        default: state_q <= ST_REQ;
      endcase
      if (bus.mem_resp_valid && !tag_ok) tag_err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Randomized bench for mem_arbiter_rr: clients issue reads/writes, a memory
// model accepts and answers them, and a negedge monitor compares the DUT
// against a reference of the arbitration rules plus write-beat/response queues.
module tb_mem_arbiter_rr;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TW = 3;
  localparam int WB = 4;
  localparam int MO = 2;
  localparam int MW = DW / 8;

  typedef struct packed {logic [MW-1:0] m; logic [DW-1:0] d;} beat_t;
  typedef struct packed {logic [N-1:0] v; logic [DW-1:0] d;} resp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_rr_if #(.N_PORTS(N), .ADDR_BITS(AW), .DATA_BITS(DW), .TAG_BITS(TW)) bus();

  mem_arbiter_rr #(
    .N_PORTS(N), .ADDR_BITS(AW), .DATA_BITS(DW), .TAG_BITS(TW),
    .WRITE_BEATS(WB), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  bit run = 1'b0;

  // client state
  bit          c_pend [N];
  bit          c_rw   [N];
  logic [AW-1:0] c_addr [N];
  logic [DW-1:0] c_wd [N][WB];
  logic [MW-1:0] c_wm [N][WB];
  int          c_bidx [N];

  // scoreboards
  beat_t exp_beat_q [N][$];
  resp_t resp_q [$];
  int    rd_q [$];

  // reference model of the arbitration rules
  int m_credit [N];
  int m_next;
  bit m_hold;
  int m_hold_port;
  bit m_wdata;
  int m_owner;
  int m_beats;
  bit m_tag_err;
  int n_grants = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic bit eligible(input int p);
    return bus.port_req_valid[p] && (bus.port_req_rw[p] || m_credit[p] < MO);
  endfunction

  task automatic clear_state();
    for (int p = 0; p < N; p++) begin
      c_pend[p] = 1'b0;
      c_bidx[p] = WB;
      m_credit[p] = 0;
      exp_beat_q[p].delete();
    end
    resp_q.delete();
    m_next = 0;
    m_hold = 1'b0;
    m_hold_port = 0;
    m_wdata = 1'b0;
    m_owner = 0;
    m_beats = 0;
    m_tag_err = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.port_req_valid = '0;
    bus.port_req_rw = '0;
    bus.port_req_addr = '0;
    bus.port_data_valid = '0;
    bus.port_data_bits = '0;
    bus.port_data_mask = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_req_data_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = '0;
    bus.mem_resp_tag = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mem_req_valid"}, bus.mem_req_valid, 0);
    chk({tag, "_port_req_ready"}, bus.port_req_ready, 0);
    chk({tag, "_port_data_ready"}, bus.port_data_ready, 0);
    chk({tag, "_mem_req_data_valid"}, bus.mem_req_data_valid, 0);
    chk({tag, "_port_resp_valid"}, bus.port_resp_valid, 0);
    chk({tag, "_tag_err"}, bus.tag_err, 0);
  endtask

  // Stimulus: clients, memory backpressure and memory responses for one cycle.
  task automatic drive();
    int r;
    resp_t e;
    for (int p = 0; p < N; p++) begin
      if (!c_pend[p] && c_bidx[p] >= WB && $urandom_range(0, 99) < 40) begin
        c_pend[p] = 1'b1;
        c_rw[p]   = ($urandom_range(0, 99) < 30);
        c_addr[p] = AW'($urandom());
        if (c_rw[p]) begin
          c_bidx[p] = 0;
          for (int b = 0; b < WB; b++) begin
            c_wd[p][b] = DW'($urandom());
            c_wm[p][b] = MW'($urandom());
            exp_beat_q[p].push_back({c_wm[p][b], c_wd[p][b]});
          end
        end
      end
      bus.port_req_valid[p] = c_pend[p];
      bus.port_req_rw[p]    = c_rw[p];
      bus.port_req_addr[p*AW +: AW] = c_addr[p];
      bus.port_data_valid[p] = (c_bidx[p] < WB) && ($urandom_range(0, 99) < 70);
      if (c_bidx[p] < WB) begin
        bus.port_data_bits[p*DW +: DW] = c_wd[p][c_bidx[p]];
        bus.port_data_mask[p*MW +: MW] = c_wm[p][c_bidx[p]];
      end else begin
        bus.port_data_bits[p*DW +: DW] = DW'($urandom());
        bus.port_data_mask[p*MW +: MW] = MW'($urandom());
      end
    end
    bus.mem_req_ready      = ($urandom_range(0, 99) < 65);
    bus.mem_req_data_ready = ($urandom_range(0, 99) < 60);
    bus.mem_resp_data      = DW'($urandom());
    r = $urandom_range(0, 99);
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_tag   = TW'($urandom());
    if (rd_q.size() > 0 && r < 40) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_tag   = TW'(rd_q.pop_front());
    end else if (r < 43) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_tag   = TW'($urandom_range(N, 7));
    end else if (r < 46) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_tag   = TW'($urandom_range(0, N - 1));
    end
    if (bus.mem_resp_valid && int'(bus.mem_resp_tag) < N) begin
      e.v = onehot(int'(bus.mem_resp_tag));
      e.d = bus.mem_resp_data;
      resp_q.push_back(e);
    end
  endtask

  // One cycle of reference prediction, comparison and model advance.
  task automatic model_step();
    int g;
    bit mvalid, fire, dvalid, bfire;
    int t;
    beat_t eb;
    resp_t er;
    g = -1;
    if (!m_wdata) begin
      if (m_hold) g = m_hold_port;
      else for (int k = 0; k < N; k++)
        if (g < 0 && eligible((m_next + k) % N)) g = (m_next + k) % N;
    end
    mvalid = (g >= 0);
    fire   = mvalid && bus.mem_req_ready;
    chk("mem_req_valid", bus.mem_req_valid, mvalid);
    chk("port_req_ready", bus.port_req_ready, fire ? onehot(g) : '0);
    if (mvalid) begin
      chk("mem_req_tag", bus.mem_req_tag, g);
      chk("mem_req_addr", bus.mem_req_addr, c_addr[g]);
      chk("mem_req_rw", bus.mem_req_rw, c_rw[g]);
    end

    dvalid = m_wdata && bus.port_data_valid[m_owner];
    bfire  = dvalid && bus.mem_req_data_ready;
    chk("mem_req_data_valid", bus.mem_req_data_valid, dvalid);
    chk("port_data_ready", bus.port_data_ready,
        (m_wdata && bus.mem_req_data_ready) ? onehot(m_owner) : '0);
    if (bus.mem_req_data_valid && bus.mem_req_data_ready) begin
      if (!m_wdata || exp_beat_q[m_owner].size() == 0) begin
        chk("beat_expected", 0, 1);
      end else begin
        eb = exp_beat_q[m_owner].pop_front();
        chk("beat_data", bus.mem_req_data_bits, eb.d);
        chk("beat_mask", bus.mem_req_data_mask, eb.m);
      end
    end

    if (resp_q.size() > 0) begin
      er = resp_q.pop_front();
      chk("port_resp_valid", bus.port_resp_valid, er.v);
      chk("port_resp_data", bus.port_resp_data, er.d);
    end else begin
      chk("port_resp_idle", bus.port_resp_valid, 0);
    end
    chk("tag_err", bus.tag_err, m_tag_err);

    // advance: write beats, then grant, then responses (issue before retire)
    if (bfire) begin
      c_bidx[m_owner]++;
      m_beats++;
      if (m_beats == WB) m_wdata = 1'b0;
    end
    if (fire) begin
      n_grants++;
      c_pend[g] = 1'b0;
      m_hold = 1'b0;
      m_next = (g + 1) % N;
      if (c_rw[g]) begin
        m_wdata = 1'b1;
        m_owner = g;
        m_beats = 0;
      end else begin
        m_credit[g]++;
        rd_q.push_back(g);
      end
    end else if (mvalid) begin
      m_hold = 1'b1;
      m_hold_port = g;
    end
    if (bus.mem_resp_valid) begin
      t = int'(bus.mem_resp_tag);
      if (t < N) begin
        if (m_credit[t] > 0) m_credit[t]--;
      end else begin
        m_tag_err = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset && run) model_step();
  end

  bit did_reset = 1'b0;

  initial begin
    clear_state();
    idle_inputs();
    // outputs must stay quiet in reset even with inputs active
    bus.port_req_valid     = '1;
    bus.port_data_valid    = '1;
    bus.mem_req_ready      = 1'b1;
    bus.mem_req_data_ready = 1'b1;
    bus.mem_resp_valid     = 1'b1;
    bus.mem_resp_tag       = 3'd7;
    #12;
    check_reset_outputs("por");
    idle_inputs();
    #16;
    reset = 1'b1;
    run   = 1'b1;

    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(posedge clk);
      #1;
      if (!did_reset && m_wdata && m_beats == 2) begin
        drive();
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_write_reset");
        clear_state();
        idle_inputs();
        did_reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
      end else begin
        drive();
      end
    end
    @(negedge clk);
    chk("mid_write_reset_reached", did_reset, 1);
    chk("grants_seen", (n_grants > 500), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
